// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one solver RAM bank between NUM_REQ requesters.
// Round-robin grant with lockable bursts. A lock is force-released after MAX_BURST
// accesses, but only while another requester is waiting. Read data is registered
// back to the owner one cycle after the access.
module ram_port_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        wr,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         ram_address,
    inout  wire  [DATA_W-1:0]         ram_data,
    output logic                      ram_WR_RD,
    output logic                      busy,
    output logic [1:0]                owner
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e            state;
    logic [1:0]        rr_ptr;
    logic [CntW-1:0]   burst_cnt;

    logic              own_req;
    logic              own_lock;
    logic              own_wr;
    logic              others;
    logic              access;
    logic              hold;
    logic [1:0]        own_next;
    logic [1:0]        arb_ptr;
    logic              win_found;
    logic [1:0]        win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [DATA_W-1:0] own_wdata;

    assign busy = (state == StGrant);

    // Owner's request/side-band and muxed address/data, selected by the registered grant
    always_comb begin
        own_req     = |(req & gnt);
        own_lock    = |(lock & gnt);
        own_wr      = |(wr & gnt);
        others      = |(req & ~gnt);
        ram_address = '0;
        own_wdata   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                ram_address = addr[k*ADDR_W +: ADDR_W];
                own_wdata   = wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign access    = busy & own_req;
    assign ram_WR_RD = access & own_wr;
    assign ram_data  = ram_WR_RD ? own_wdata : 'z;

    // Keep the grant on a locked burst unless the cap is hit while someone else waits
    assign hold = access & own_lock & (~others | (burst_cnt < CntW'(MAX_BURST - 1)));

    assign own_next = (owner == 2'(NUM_REQ - 1)) ? 2'd0 : owner + 2'd1;
    // On release the search starts just after the outgoing owner, so it comes last
    assign arb_ptr  = busy ? own_next : rr_ptr;

    // Round-robin search: first requester at or after arb_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!win_found && req[k] && ((32'(arb_ptr) + i) % NUM_REQ == k)) begin
                    win_found = 1'b1;
                    win_idx   = 2'(k);
                end
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            win_oh[k] = (win_idx == 2'(k));
        end
    end

    // Grant FSM with registered grant/owner and read-return path
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            gnt       <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            rvalid    <= '0;
            rdata     <= '0;
        end else begin
            rvalid <= '0;
            if (access && !own_wr) begin
                rdata  <= ram_data;
                rvalid <= gnt;
            end
            case (state)
                StIdle: begin
                    if (win_found) begin
                        state     <= StGrant;
                        gnt       <= win_oh;
                        owner     <= win_idx;
                        burst_cnt <= '0;
                    end
                end
                StGrant: begin
                    if (hold) begin
                        if (burst_cnt != {CntW{1'b1}}) begin
                            burst_cnt <= burst_cnt + CntW'(1);
                        end
                    end else begin
                        rr_ptr    <= own_next;
                        burst_cnt <= '0;
                        if (win_found) begin
                            gnt   <= win_oh;
                            owner <= win_idx;
                        end else begin
                            state <= StIdle;
                            gnt   <= '0;
                            owner <= '0;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    gnt   <= '0;
                    owner <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed stimulus, scoreboard queues of expected
// RAM accesses and read returns, checked by a negedge monitor.
module tb_ram_port_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req;
    logic [NR-1:0]  lock;
    logic [NR-1:0]  wr;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]  gnt;
    logic [NR-1:0]  rvalid;
    logic [DW-1:0]  rdata;
    logic [AW-1:0]  ram_address;
    wire  [DW-1:0]  ram_data;
    logic           ram_WR_RD;
    logic           busy;
    logic [1:0]     owner;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lock        (lock),
        .wr          (wr),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_WR_RD   (ram_WR_RD),
        .busy        (busy),
        .owner       (owner)
    );

    // RAM model: answers combinationally whenever the arbiter is not write-strobing
    function automatic logic [DW-1:0] ram_model(input logic [AW-1:0] a);
        if (a == 64'd9) return 64'h1234;
        return a ^ 64'hA5A5;
    endfunction

    assign ram_data = ram_WR_RD ? 'z : ram_model(ram_address);

    typedef struct packed {
        logic [NR-1:0] gnt;
        logic [1:0]    owner;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct packed {
        logic [NR-1:0] oh;
        logic [DW-1:0] data;
    } rd_t;

    acc_t aexp_q[$];
    rd_t  rexp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_en   = 1'b0;
    logic rd_prev  = 1'b0;
    acc_t a_e;
    rd_t  r_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got an event with no expectation queued", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int k, input logic [63:0] a, input logic [63:0] d);
        addr[k*AW +: AW]  = a;
        wdata[k*DW +: DW] = d;
    endtask

    task automatic exp_wr(input int o, input logic [63:0] a, input logic [63:0] d);
        aexp_q.push_back('{gnt: NR'(1 << o), owner: 2'(o), wr: 1'b1, addr: a, data: d});
    endtask

    task automatic exp_acc_rd(input int o, input logic [63:0] a);
        aexp_q.push_back('{gnt: NR'(1 << o), owner: 2'(o), wr: 1'b0, addr: a, data: '0});
    endtask

    task automatic exp_rv(input int o, input logic [63:0] d);
        rexp_q.push_back('{oh: NR'(1 << o), data: d});
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_gnt"}, 64'(gnt), 64'd0);
        check({tag, "_wr_rd"}, 64'(ram_WR_RD), 64'd0);
        check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
        check({tag, "_owner"}, 64'(owner), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rdata"}, rdata, 64'd0);
        check({tag, "_address"}, ram_address, 64'd0);
        // Only the RAM model drives the bus when the arbiter is released
        check({tag, "_bus"}, ram_data, 64'hA5A5);
    endtask

    task automatic drain(input string tag);
        check({tag, "_acc_left"}, 64'(aexp_q.size()), 64'd0);
        check({tag, "_rd_left"}, 64'(rexp_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    // Monitor: pops expected read returns on rvalid and expected accesses on each access cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_prev) begin
                if (rexp_q.size() == 0) begin
                    fail_now("rvalid_queue");
                end else begin
                    r_e = rexp_q.pop_front();
                    check("rvalid", 64'(rvalid), 64'(r_e.oh));
                    check("rdata", rdata, r_e.data);
                end
            end else if (rvalid != '0) begin
                check("rvalid_spurious", 64'(rvalid), 64'd0);
            end

            rd_prev = 1'b0;
            if (busy && ((req & gnt) != '0)) begin
                if (aexp_q.size() == 0) begin
                    fail_now("access_queue");
                end else begin
                    a_e = aexp_q.pop_front();
                    check("gnt", 64'(gnt), 64'(a_e.gnt));
                    check("owner", 64'(owner), 64'(a_e.owner));
                    check("wr_rd", 64'(ram_WR_RD), 64'(a_e.wr));
                    check("address", ram_address, a_e.addr);
                    if (a_e.wr) check("wdata_bus", ram_data, a_e.data);
                    rd_prev = !a_e.wr && !rst;
                end
            end else if (ram_WR_RD) begin
                check("strobe_no_access", 64'(ram_WR_RD), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        req   = 3'b111;
        lock  = '0;
        wr    = '0;
        addr  = '0;
        wdata = '0;

        // Reset held two cycles with everyone requesting
        tick(1);
        reset_checks("rst1");
        tick(1);
        reset_checks("rst2");
        rst    = 1'b0;
        req    = '0;
        mon_en = 1'b1;
        tick(1);

        // Round robin from reset: 0,1,2,0,1,2 with no gaps
        wr = 3'b111;
        set_req(0, 64'h10, 64'h100);
        set_req(1, 64'h20, 64'h101);
        set_req(2, 64'h30, 64'h102);
        for (int r = 0; r < 2; r++) begin
            exp_wr(0, 64'h10, 64'h100);
            exp_wr(1, 64'h20, 64'h101);
            exp_wr(2, 64'h30, 64'h102);
        end
        req = 3'b111;
        tick(7);
        req = '0;
        tick(2);
        drain("rr");

        // Single write by requester 1
        wr = 3'b010;
        set_req(1, 64'd5, 64'hABCD);
        exp_wr(1, 64'd5, 64'hABCD);
        req = 3'b010;
        tick(2);
        req = '0;
        tick(2);
        drain("single_wr");

        // Locked requester alone keeps the grant past MAX_BURST
        wr   = 3'b101;
        lock = 3'b001;
        set_req(0, 64'h40, 64'h55);
        set_req(2, 64'h50, 64'h77);
        for (int r = 0; r < 6; r++) exp_wr(0, 64'h40, 64'h55);
        req = 3'b001;
        tick(7);
        req  = '0;
        lock = '0;
        tick(2);
        drain("lock_alone");

        // Locked burst capped at 4 while requester 2 waits
        for (int r = 0; r < 4; r++) exp_wr(0, 64'h40, 64'h55);
        exp_wr(2, 64'h50, 64'h77);
        lock = 3'b001;
        req  = 3'b001;
        tick(1);
        req = 3'b101;
        tick(4);
        req  = 3'b100;
        lock = '0;
        tick(1);
        req = '0;
        tick(2);
        drain("burst_cap");

        // Single read: rvalid/rdata one cycle after the access
        wr = '0;
        set_req(2, 64'd9, 64'h0);
        exp_acc_rd(2, 64'd9);
        exp_rv(2, 64'h1234);
        req = 3'b100;
        tick(2);
        req = '0;
        tick(3);
        drain("read1");

        // Three back-to-back reads give three pulses
        exp_acc_rd(2, 64'd9);
        exp_rv(2, 64'h1234);
        exp_acc_rd(2, 64'd10);
        exp_rv(2, 64'hA5AF);
        exp_acc_rd(2, 64'd11);
        exp_rv(2, 64'hA5AE);
        req = 3'b100;
        tick(2);
        set_req(2, 64'd10, 64'h0);
        tick(1);
        set_req(2, 64'd11, 64'h0);
        tick(1);
        req = '0;
        tick(3);
        drain("read3");

        // Reset during a locked read burst by 1: the interrupted read never returns
        set_req(1, 64'd9, 64'h0);
        exp_acc_rd(1, 64'd9);
        exp_rv(1, 64'h1234);
        exp_acc_rd(1, 64'd9);
        exp_rv(1, 64'h1234);
        exp_acc_rd(1, 64'd9);
        req = 3'b010;
        tick(2);
        lock = 3'b010;
        tick(1);
        rst = 1'b1;
        tick(1);
        reset_checks("rst_mid");
        rst  = 1'b0;
        lock = '0;
        wr   = 3'b110;
        set_req(1, 64'h60, 64'h61);
        set_req(2, 64'h70, 64'h71);
        exp_wr(1, 64'h60, 64'h61);
        exp_wr(2, 64'h70, 64'h71);
        req = 3'b110;
        tick(3);
        req = '0;
        tick(3);
        drain("rst_mid");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
